// File: rtl/enemy_wave_scheduler.sv
// Per-frame spawn/retire sequencer for a pool of enemy sprite slots.
// Tracks wave progression, kill count and end of game (escape or final wave cleared).
module enemy_wave_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int WAVE_SIZE = 8,
  parameter int MAX_WAVE  = 15,
  parameter int SPAWN_GAP = 60,
  parameter int CLEAR_GAP = 120,
  parameter int X_BASE    = 64,
  parameter int X_STEP    = 128
) (
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic                 start,
  input  logic [NUM_SLOTS-1:0] hit,
  input  logic [NUM_SLOTS-1:0] escaped,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic [NUM_SLOTS-1:0] slot_spawn,
  output logic [9:0]           spawn_x,
  output logic [3:0]           wave,
  output logic [7:0]           kills,
  output logic                 game_over,
  output logic                 win
);
  typedef enum logic [1:0] {IDLE, RUN, CLEAR, OVER} state_t;

  localparam logic [15:0] SPAWN_RELOAD = 16'(SPAWN_GAP - 1);
  localparam logic [15:0] CLEAR_RELOAD = 16'(CLEAR_GAP - 1);
  localparam logic [15:0] WAVE_TOTAL   = 16'(WAVE_SIZE);
  localparam logic [3:0]  LAST_WAVE    = 4'(MAX_WAVE);
  localparam logic [2:0]  LAST_LANE    = 3'(NUM_SLOTS - 1);

  state_t state_reg, state_next;
  logic [15:0] gap_reg, gap_next;
  logic [15:0] spawned_reg, spawned_next;
  logic [2:0]  lane_reg, lane_next;
  logic [NUM_SLOTS-1:0] slot_active_next, slot_spawn_next;
  logic [9:0]  spawn_x_next;
  logic [3:0]  wave_next;
  logic [7:0]  kills_next;
  logic        game_over_next, win_next;

  logic [NUM_SLOTS-1:0] free_mask, pick, kill_mask, esc_mask;
  logic [3:0] kill_cnt;
  logic [8:0] kill_sum;
  logic [9:0] lane_x;
  logic       gap_zero, can_spawn, wave_done, escape;

  // Hit beats escape on the same slot; inactive slots never retire.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_retire
      assign kill_mask[gi] = hit[gi] & slot_active[gi];
      assign esc_mask[gi]  = escaped[gi] & slot_active[gi] & ~hit[gi];
    end
  endgenerate

  // Free search uses the registered mask, so a slot retired this frame is reusable next frame.
  assign free_mask = ~slot_active;
  assign pick      = free_mask & (~free_mask + NUM_SLOTS'(1));
  assign gap_zero  = (gap_reg == 16'd0);
  assign can_spawn = gap_zero && (spawned_reg < WAVE_TOTAL) && (|free_mask);
  assign wave_done = (spawned_reg == WAVE_TOTAL) && (slot_active == '0);
  assign escape    = |esc_mask;
  assign lane_x    = 10'(X_BASE + X_STEP * int'(lane_reg));

  always_comb begin
    kill_cnt = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) kill_cnt = kill_cnt + 4'(kill_mask[i]);
  end
  assign kill_sum = {1'b0, kills} + {5'b0, kill_cnt};

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE, OVER: if (start) state_next = RUN;
      RUN: begin
        if (escape)         state_next = OVER;
        else if (wave_done) state_next = CLEAR;
      end
      CLEAR: if (gap_zero) state_next = (wave == LAST_WAVE) ? OVER : RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gap_next         = gap_reg;
    spawned_next     = spawned_reg;
    lane_next        = lane_reg;
    slot_active_next = slot_active;
    slot_spawn_next  = '0;
    spawn_x_next     = spawn_x;
    wave_next        = wave;
    kills_next       = kills;
    game_over_next   = game_over;
    win_next         = win;
    unique case (state_reg)
      IDLE, OVER: begin
        slot_active_next = '0;
        if (start) begin
          wave_next      = 4'd1;
          kills_next     = 8'd0;
          spawned_next   = 16'd0;
          lane_next      = 3'd0;
          gap_next       = SPAWN_RELOAD;
          game_over_next = 1'b0;
          win_next       = 1'b0;
        end
      end
      RUN: begin
        kills_next       = kill_sum[8] ? 8'hFF : kill_sum[7:0];
        slot_active_next = slot_active & ~kill_mask;
        if (escape) begin
          game_over_next   = 1'b1;
          slot_active_next = '0;
        end else if (wave_done) begin
          gap_next = CLEAR_RELOAD;
        end else if (can_spawn) begin
          slot_spawn_next  = pick;
          slot_active_next = slot_active_next | pick;
          spawn_x_next     = lane_x;
          lane_next        = (lane_reg == LAST_LANE) ? 3'd0 : lane_reg + 3'd1;
          spawned_next     = spawned_reg + 16'd1;
          gap_next         = SPAWN_RELOAD;
        end else if (!gap_zero) begin
          gap_next = gap_reg - 16'd1;
        end
      end
      CLEAR: begin
        if (gap_zero) begin
          if (wave == LAST_WAVE) begin
            win_next = 1'b1;
          end else begin
            wave_next    = wave + 4'd1;
            spawned_next = 16'd0;
            gap_next     = SPAWN_RELOAD;
          end
        end else begin
          gap_next = gap_reg - 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      gap_reg     <= '0;
      spawned_reg <= '0;
      lane_reg    <= '0;
      slot_active <= '0;
      slot_spawn  <= '0;
      spawn_x     <= '0;
      wave        <= '0;
      kills       <= '0;
      game_over   <= 1'b0;
      win         <= 1'b0;
    end else begin
      gap_reg     <= gap_next;
      spawned_reg <= spawned_next;
      lane_reg    <= lane_next;
      slot_active <= slot_active_next;
      slot_spawn  <= slot_spawn_next;
      spawn_x     <= spawn_x_next;
      wave        <= wave_next;
      kills       <= kills_next;
      game_over   <= game_over_next;
      win         <= win_next;
    end
  end
endmodule
